fir_mac_seq: RTL and testbench

//  Sequencer for a time-multiplexed single-MAC FIR decimator. Accepts AXI-stream samples and

---
 rtl/fir_mac_seq.sv | 154 +++++++++++++++
 tb/tb_fir_mac_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// Single-MAC FIR decimator sequencer: CLR sweep, sample intake, TAPS-cycle MAC pass, result handoff.
// out_load lands TAPS+MAC_LAT cycles after the group's last sample; intake stalls outside IDLE.
module fir_mac_seq #(
   parameter int TAPS    = 13,
   parameter int DECI    = 2,
   parameter int MAC_LAT = 2,
   localparam int AW     = $clog2(TAPS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s_axis_tvalid,
   output logic          s_axis_tready,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   output logic          wr_en,
   output logic          wr_zero,
   output logic [AW-1:0] wr_addr,
   output logic [AW-1:0] rd_addr,
   output logic [AW-1:0] coef_addr,
   output logic          mac_en,
   output logic          mac_clr,
   output logic          out_load
);
   localparam int DW = (DECI > 1) ? $clog2(DECI) : 1;
   localparam logic [AW-1:0] LAST_TAP  = AW'(TAPS - 1);
   localparam logic [DW-1:0] LAST_DECI = DW'(DECI - 1);
   localparam logic [3:0]    LAST_W    = 4'(MAC_LAT - 1);

   typedef enum logic [1:0] {S_CLR, S_IDLE, S_MAC, S_WAIT} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] base_q, base_d;
   logic [DW-1:0] deci_q, deci_d;
   logic [3:0]    w_q, w_d;
   logic          tvalid_q, tvalid_d;

   logic          s_rdy, s_en, m_en, load;
   logic          wr_en_c, wr_zero_c, mac_en_c, mac_clr_c;
   logic [AW-1:0] wr_addr_c, rd_addr_c, coef_addr_c;
   logic [AW:0]   rd_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_CLR;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         base_q   <= '0;
         deci_q   <= '0;
         w_q      <= '0;
         tvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         base_q   <= base_d;
         deci_q   <= deci_d;
         w_q      <= w_d;
         tvalid_q <= tvalid_d;
      end
   end

   // Tap k reads the sample k steps older than base, wrapping below address 0.
   assign rd_wrap = {1'b0, base_q} + (AW+1)'(TAPS) - {1'b0, cnt_q};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_ptr_d    = wr_ptr_q;
      base_d      = base_q;
      deci_d      = deci_q;
      w_d         = w_q;
      s_rdy       = 1'b0;
      s_en        = 1'b0;
      load        = 1'b0;
      wr_en_c     = 1'b0;
      wr_zero_c   = 1'b0;
      wr_addr_c   = '0;
      rd_addr_c   = '0;
      coef_addr_c = '0;
      mac_en_c    = 1'b0;
      mac_clr_c   = 1'b0;
      m_en        = tvalid_q & m_axis_tready;
      case (state_q)
         S_CLR: begin
            wr_en_c   = 1'b1;
            wr_zero_c = 1'b1;
            wr_addr_c = cnt_q;
            if (cnt_q == LAST_TAP) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            s_rdy     = 1'b1;
            s_en      = s_axis_tvalid;
            wr_en_c   = s_en;
            wr_addr_c = wr_ptr_q;
            if (s_en) begin
               wr_ptr_d = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
               if (deci_q == LAST_DECI) begin
                  deci_d  = '0;
                  base_d  = wr_ptr_q;
                  cnt_d   = '0;
                  state_d = S_MAC;
               end else begin
                  deci_d = deci_q + 1'b1;
               end
            end
         end
         S_MAC: begin
            mac_en_c    = 1'b1;
            mac_clr_c   = (cnt_q == '0);
            coef_addr_c = cnt_q;
            rd_addr_c   = (cnt_q > base_q) ? rd_wrap[AW-1:0] : base_q - cnt_q;
            if (cnt_q == LAST_TAP) begin
               cnt_d   = '0;
               w_d     = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (w_q == LAST_W) begin
               // An unconsumed result is never overwritten; a same-cycle consume frees the slot.
               if (!(tvalid_q && !m_axis_tready)) begin
                  load    = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               w_d = w_q + 4'd1;
            end
         end
         default: state_d = S_CLR;
      endcase
      tvalid_d = load ? 1'b1 : (m_en ? 1'b0 : tvalid_q);
   end

   assign s_axis_tready = rst_n & s_rdy;
   assign m_axis_tvalid = tvalid_q;
   assign wr_en         = rst_n & wr_en_c;
   assign wr_zero       = rst_n & wr_zero_c;
   assign wr_addr       = rst_n ? wr_addr_c : '0;
   assign rd_addr       = rst_n ? rd_addr_c : '0;
   assign coef_addr     = rst_n ? coef_addr_c : '0;
   assign mac_en        = rst_n & mac_en_c;
   assign mac_clr       = rst_n & mac_clr_c;
   assign out_load      = rst_n & load;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: directed timing checks plus a random-traffic FIR scoreboard.
module tb_fir_mac_seq;
   localparam int TAPS    = 13;
   localparam int DECI    = 2;
   localparam int MAC_LAT = 2;
   localparam int AW      = $clog2(TAPS);

   logic clk = 1'b0;
   logic rst_n;
   logic s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready;
   logic wr_en, wr_zero, mac_en, mac_clr, out_load;
   logic [AW-1:0] wr_addr, rd_addr, coef_addr;

   logic s_tvalid1, s_tready1, m_tvalid1, m_tready1;
   logic wr_en1, wr_zero1, mac_en1, mac_clr1, out_load1;
   logic [AW-1:0] wr_addr1, rd_addr1, coef_addr1;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   fir_mac_seq #(.TAPS(TAPS), .DECI(DECI), .MAC_LAT(MAC_LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .wr_en(wr_en), .wr_zero(wr_zero), .wr_addr(wr_addr), .rd_addr(rd_addr),
      .coef_addr(coef_addr), .mac_en(mac_en), .mac_clr(mac_clr), .out_load(out_load));

   fir_mac_seq #(.TAPS(TAPS), .DECI(1), .MAC_LAT(MAC_LAT)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tvalid(s_tvalid1), .s_axis_tready(s_tready1),
      .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready1),
      .wr_en(wr_en1), .wr_zero(wr_zero1), .wr_addr(wr_addr1), .rd_addr(rd_addr1),
      .coef_addr(coef_addr1), .mac_en(mac_en1), .mac_clr(mac_clr1), .out_load(out_load1));

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: sample history, FIR outputs expected in order, and the external datapath.
   int coef [16];
   int mbuf [16];
   int hist [$];
   int expq [$];
   int s_data;
   int acc, res, n_acc, n_load;
   int n_acc1, n_load1, last_addr1;

   always @(negedge clk) begin
      if (!rst_n) begin
         hist.delete();
         for (int i = 0; i < TAPS; i++) hist.push_back(0);
         expq.delete();
         acc = 0; res = 0; n_acc = 0; n_load = 0;
      end else begin
         if (m_axis_tvalid && m_axis_tready) begin
            if (expq.size() == 0) check("sb_unexpected", expq.size(), 1);
            else check("sb_result", res, expq.pop_front());
         end
         if (out_load) begin
            res = acc;
            n_load++;
         end
         if (mac_en) acc = (mac_clr ? 0 : acc) + coef[coef_addr] * mbuf[rd_addr];
         if (wr_en) mbuf[wr_addr] = wr_zero ? 0 : s_data;
         if (s_axis_tvalid && s_axis_tready) begin
            int y;
            check("wr_ptr", wr_addr, n_acc % TAPS);
            hist.push_back(s_data);
            n_acc++;
            if (n_acc % DECI == 0) begin
               y = 0;
               for (int k = 0; k < TAPS; k++) y += coef[k] * hist[hist.size() - 1 - k];
               expq.push_back(y);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         n_acc1 = 0; n_load1 = 0; last_addr1 = 0;
      end else begin
         if (mac_en1 && mac_clr1) check("d1_base", rd_addr1, last_addr1);
         if (out_load1) n_load1++;
         if (s_tvalid1 && s_tready1) begin
            check("d1_wr_ptr", wr_addr1, n_acc1 % TAPS);
            last_addr1 = n_acc1 % TAPS;
            n_acc1++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd_sample();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   task automatic clr_sweep();
      for (int i = 0; i < TAPS; i++) begin
         #1;
         check("clr_wr_en", wr_en, 1);
         check("clr_wr_zero", wr_zero, 1);
         check("clr_wr_addr", wr_addr, i);
         check("clr_tready", s_axis_tready, 0);
         tick();
      end
      #1 check("idle_tready", s_axis_tready, 1);
   endtask

   task automatic send_n(input int n);
      int got = 0;
      int budget = 0;
      s_axis_tvalid = 1'b1;
      s_data = rnd_sample();
      while (got < n && budget < 500) begin
         #1;
         if (s_axis_tready) got++;
         tick();
         s_data = rnd_sample();
         budget++;
      end
      s_axis_tvalid = 1'b0;
      check("send_timeout", got, n);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int b;
      rst_n = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1; s_data = 0;
      s_tvalid1 = 1'b0; m_tready1 = 1'b1;
      for (int k = 0; k < 16; k++) coef[k] = (k < TAPS) ? int'($urandom_range(0, 63)) - 32 : 0;
      for (int k = 0; k < 16; k++) mbuf[k] = 0;
      repeat (3) tick();
      #1;
      check("rst_wr_en", wr_en, 0);
      check("rst_tready", s_axis_tready, 0);
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_mac_en", mac_en, 0);
      check("rst_out_load", out_load, 0);
      rst_n = 1'b1;
      clr_sweep();

      // Two back-to-back samples, then one full MAC pass with fixed latency.
      s_axis_tvalid = 1'b1; s_data = rnd_sample();
      #1 check("t2_wr_en0", wr_en, 1); check("t2_wr_addr0", wr_addr, 0);
      tick();
      s_data = rnd_sample();
      #1 check("t2_wr_addr1", wr_addr, 1);
      tick();
      s_axis_tvalid = 1'b0;
      for (int k = 0; k < TAPS; k++) begin
         #1;
         check("t2_mac_en", mac_en, 1);
         check("t2_mac_clr", mac_clr, (k == 0) ? 1 : 0);
         check("t2_coef_addr", coef_addr, k);
         check("t2_rd_addr", rd_addr, (1 - k + TAPS) % TAPS);
         check("t2_tready", s_axis_tready, 0);
         tick();
      end
      #1 check("t2_early_load", out_load, 0);
      tick();
      #1 check("t2_out_load", out_load, 1); check("t2_tvalid_pre", m_axis_tvalid, 0);
      tick();
      #1 check("t2_tvalid", m_axis_tvalid, 1);
      tick();
      #1 check("t2_consumed", m_axis_tvalid, 0);

      // Backpressure: second pass must hold in WAIT until the first result is taken.
      m_axis_tready = 1'b0;
      send_n(4);
      repeat (40) tick();
      #1;
      check("t3_stall_load", out_load, 0);
      check("t3_stall_tready", s_axis_tready, 0);
      check("t3_stall_tvalid", m_axis_tvalid, 1);
      check("t3_stall_mac", mac_en, 0);
      m_axis_tready = 1'b1;
      #1 check("t3_load_on_consume", out_load, 1);
      tick();
      #1 check("t3_tvalid_kept", m_axis_tvalid, 1);
      tick();
      #1 check("t3_tvalid_drop", m_axis_tvalid, 0);

      // DECI=1 instance: one pass per sample, pointer wraps past TAPS-1.
      s_tvalid1 = 1'b1;
      b = 0;
      while (n_acc1 < 20 && b < 2000) begin
         tick();
         b++;
      end
      s_tvalid1 = 1'b0;
      repeat (30) tick();
      check("t4_accepts", n_acc1, 20);
      check("t4_loads", n_load1, 20);

      // Random traffic on both sides against the FIR reference.
      for (int c = 0; c < 800; c++) begin
         s_axis_tvalid = 1'($urandom_range(0, 1));
         s_data = rnd_sample();
         m_axis_tready = ($urandom_range(0, 3) != 0);
         tick();
      end
      s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
      repeat (40) tick();
      check("t5_drained", expq.size(), 0);
      check("t5_loads", n_load, n_acc / DECI);

      // Reset in the middle of a MAC pass while a result is still pending.
      m_axis_tready = 1'b0;
      send_n(4);
      repeat (5) tick();
      #1 check("t6_mac_k5", coef_addr, 5); check("t6_mac_en", mac_en, 1);
      rst_n = 1'b0;
      #1;
      check("t6_mac_en_rst", mac_en, 0);
      check("t6_wr_en_rst", wr_en, 0);
      check("t6_load_rst", out_load, 0);
      check("t6_tready_rst", s_axis_tready, 0);
      check("t6_tvalid_rst", m_axis_tvalid, 0);
      tick(); tick();
      rst_n = 1'b1;
      m_axis_tready = 1'b1;
      clr_sweep();
      send_n(2);
      repeat (30) tick();
      check("t6_post_drain", expq.size(), 0);
      check("t6_post_loads", n_load, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
